sync_fifo_flagged: RTL and testbench

Parametrised single-clock FIFO, the successor to the first-generation UART FIFO. It generalises width and depth and adds a selectable first-word-fall-through (FWFT) output mode. It also adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits between the UART controller datapath and its bus-side register interface, one instance per direction.

---
 rtl/sync_fifo_flagged.sv | 119 +++++++++++
 tb/tb_sync_fifo_flagged.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with selectable first-word-fall-through output, occupancy
// count, programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_flagged #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH_POW  = 4,
   parameter int unsigned FWFT       = 0
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  writeEn_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  readEn_in,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic [DEPTH_POW:0]    afThresh_in,
   input  logic [DEPTH_POW:0]    aeThresh_in,
   input  logic                  clearErr_in,
   output logic [DEPTH_POW:0]    count_out,
   output logic                  full_flag,
   output logic                  empty_flag,
   output logic                  halfFull_flag,
   output logic                  almostFull_flag,
   output logic                  almostEmpty_flag,
   output logic                  overflow_flag,
   output logic                  underflow_flag
);

   localparam int unsigned DEPTH = 1 << DEPTH_POW;
   localparam int unsigned PW    = DEPTH_POW + 1;

   localparam logic [PW-1:0] DepthCnt = PW'(DEPTH);
   localparam logic [PW-1:0] HalfCnt  = PW'(DEPTH / 2);
   localparam logic [PW-1:0] PtrOne   = PW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        count;
   logic [DEPTH_POW-1:0] wr_addr;
   logic [DEPTH_POW-1:0] rd_addr;
   logic                 rd_acc;
   logic                 wr_acc;
   logic                 overflow;
   logic                 underflow;

   assign wr_addr = wr_ptr[DEPTH_POW-1:0];
   assign rd_addr = rd_ptr[DEPTH_POW-1:0];

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_acc = readEn_in & ~empty_flag;
   assign wr_acc = writeEn_in & (~full_flag | rd_acc);

   // Flags decode the registered count only; no lookahead.
   assign count_out        = count;
   assign full_flag        = (count == DepthCnt);
   assign empty_flag       = (count == '0);
   assign halfFull_flag    = (count >= HalfCnt);
   assign almostFull_flag  = (count >= afThresh_in);
   assign almostEmpty_flag = (count <= aeThresh_in);
   assign overflow_flag    = overflow;
   assign underflow_flag   = underflow;

   // Storage is not reset; writes are suppressed while reset is held.
   always_ff @(posedge clk_in) begin
      if (wr_acc && !rst_in) begin
         mem[wr_addr] <= data_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PtrOne;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + PtrOne;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + PtrOne;
            2'b01:   count <= count - PtrOne;
            default: count <= count;
         endcase
         // Setting wins over a simultaneous clear.
         if (writeEn_in && !wr_acc) begin
            overflow <= 1'b1;
         end else if (clearErr_in) begin
            overflow <= 1'b0;
         end
         if (readEn_in && !rd_acc) begin
            underflow <= 1'b1;
         end else if (clearErr_in) begin
            underflow <= 1'b0;
         end
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign data_out = empty_flag ? '0 : mem[rd_addr];
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            dout_q <= '0;
         end else if (rd_acc) begin
            dout_q <= mem[rd_addr];
         end
      end

      assign data_out = dout_q;
   end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Randomised bench for sync_fifo_flagged: one standard and one FWFT instance
// share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_flagged;

   localparam int DW    = 8;
   localparam int DP    = 4;
   localparam int DEPTH = 1 << DP;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          writeEn_in;
   logic [DW-1:0] data_in;
   logic          readEn_in;
   logic [DP:0]   afThresh_in;
   logic [DP:0]   aeThresh_in;
   logic          clearErr_in;

   logic [DW-1:0] dout0, dout1;
   logic [DP:0]   cnt0, cnt1;
   logic          full0, empty0, half0, af0, ae0, ov0, un0;
   logic          full1, empty1, half1, af1, ae1, ov1, un1;

   always #5 clk_in = ~clk_in;

   sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH_POW(DP), .FWFT(0)) dut_std (
      .clk_in(clk_in), .rst_in(rst_in), .writeEn_in(writeEn_in), .data_in(data_in),
      .readEn_in(readEn_in), .data_out(dout0), .afThresh_in(afThresh_in),
      .aeThresh_in(aeThresh_in), .clearErr_in(clearErr_in), .count_out(cnt0),
      .full_flag(full0), .empty_flag(empty0), .halfFull_flag(half0),
      .almostFull_flag(af0), .almostEmpty_flag(ae0), .overflow_flag(ov0),
      .underflow_flag(un0)
   );

   sync_fifo_flagged #(.DATA_WIDTH(DW), .DEPTH_POW(DP), .FWFT(1)) dut_fwft (
      .clk_in(clk_in), .rst_in(rst_in), .writeEn_in(writeEn_in), .data_in(data_in),
      .readEn_in(readEn_in), .data_out(dout1), .afThresh_in(afThresh_in),
      .aeThresh_in(aeThresh_in), .clearErr_in(clearErr_in), .count_out(cnt1),
      .full_flag(full1), .empty_flag(empty1), .halfFull_flag(half1),
      .almostFull_flag(af1), .almostEmpty_flag(ae1), .overflow_flag(ov1),
      .underflow_flag(un1)
   );

   // Reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   bit            m_ov, m_un;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string ctx);
      int n;
      logic [DW-1:0] fw;
      n  = q.size();
      fw = (n > 0) ? q[0] : '0;
      check({ctx, ".count"},   32'(cnt0), 32'(n));
      check({ctx, ".full"},    32'(full0), 32'(n == DEPTH));
      check({ctx, ".empty"},   32'(empty0), 32'(n == 0));
      check({ctx, ".half"},    32'(half0), 32'(n >= DEPTH / 2));
      check({ctx, ".afull"},   32'(af0), 32'(n >= int'(afThresh_in)));
      check({ctx, ".aempty"},  32'(ae0), 32'(n <= int'(aeThresh_in)));
      check({ctx, ".ovf"},     32'(ov0), 32'(m_ov));
      check({ctx, ".unf"},     32'(un0), 32'(m_un));
      check({ctx, ".dout"},    32'(dout0), 32'(m_dout));
      check({ctx, ".f_count"}, 32'(cnt1), 32'(n));
      check({ctx, ".f_empty"}, 32'(empty1), 32'(n == 0));
      check({ctx, ".f_full"},  32'(full1), 32'(n == DEPTH));
      check({ctx, ".f_ovf"},   32'(ov1), 32'(m_ov));
      check({ctx, ".f_unf"},   32'(un1), 32'(m_un));
      check({ctx, ".f_dout"},  32'(dout1), 32'(fw));
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
   endtask

   // One clock cycle of stimulus, model update and full output comparison.
   task automatic cyc(input string ctx, input bit we, input logic [DW-1:0] d,
                      input bit re, input bit clr);
      bit racc, wacc;
      writeEn_in  = we;
      data_in     = d;
      readEn_in   = re;
      clearErr_in = clr;
      racc = re && (q.size() > 0);
      wacc = we && ((q.size() < DEPTH) || racc);
      @(posedge clk_in);
      #1;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
      if (we && !wacc) m_ov = 1'b1;
      else if (clr) m_ov = 1'b0;
      if (re && !racc) m_un = 1'b1;
      else if (clr) m_un = 1'b0;
      writeEn_in  = 1'b0;
      readEn_in   = 1'b0;
      clearErr_in = 1'b0;
      check_all(ctx);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in      = 1'b1;
      writeEn_in  = 1'b0;
      readEn_in   = 1'b0;
      clearErr_in = 1'b0;
      data_in     = '0;
      afThresh_in = 5'd14;
      aeThresh_in = 5'd2;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      check_all("reset");
      cyc("idle", 1'b0, 8'h00, 1'b0, 1'b0);

      // Fill to full, then one rejected write
      for (int i = 1; i <= DEPTH; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0);
      cyc("overflow", 1'b1, 8'h99, 1'b0, 1'b0);

      // Simultaneous push/pop while full, then drain across the pointer wrap
      cyc("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // Underflow, clear, clear racing a bad read
      cyc("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
      cyc("clear", 1'b0, 8'h00, 1'b0, 1'b1);
      cyc("clr_vs_bad_rd", 1'b0, 8'h00, 1'b1, 1'b1);
      cyc("clear2", 1'b0, 8'h00, 1'b0, 1'b1);

      // Fall-through on empty, and push+pop on empty rejects the read
      cyc("fwft_wr", 1'b1, 8'h5C, 1'b0, 1'b0);
      cyc("fwft_hold", 1'b0, 8'h00, 1'b0, 1'b0);
      cyc("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);
      cyc("empty_rw", 1'b1, 8'h77, 1'b1, 1'b1);
      cyc("empty_rw_pop", 1'b0, 8'h00, 1'b1, 1'b1);

      // Randomised traffic with live threshold changes; write-biased then read-biased
      for (int i = 0; i < 800; i++) begin
         int wp;
         wp = (i < 400) ? 65 : 35;
         if ($urandom_range(0, 15) == 0) begin
            afThresh_in = 5'($urandom_range(0, 31));
            aeThresh_in = 5'($urandom_range(0, 31));
         end
         cyc("rand", ($urandom_range(0, 99) < wp), 8'($urandom),
             ($urandom_range(0, 99) >= wp), ($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset mid-burst at count 9
      afThresh_in = 5'd14;
      aeThresh_in = 5'd2;
      while (q.size() > 0) cyc("pre_drain", 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) cyc("burst", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      writeEn_in = 1'b1;
      data_in    = 8'hEE;
      #2;
      rst_in = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      writeEn_in = 1'b0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      check_all("post_rst");
      cyc("wr33", 1'b1, 8'h33, 1'b0, 1'b0);
      cyc("rd33", 1'b0, 8'h00, 1'b1, 1'b0);
      check("rd33_value", 32'(dout0), 32'h33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
